// File: rtl/audio_output_pdm_if.sv
// Playback port bundle for audio_output_pdm: switches, OutputBuffer port-B read bus and audio jack outputs.
// master = playback engine side, slave = buffer/board side.
interface audio_output_pdm_if;
  logic [1:0]  sw;
  logic [15:0] end_address;
  logic [15:0] read_address;
  logic        read_enable;
  logic [15:0] read_data;
  logic        PDM_out;
  logic        AUD_SD;
  logic        busy;
  logic        done;

  modport master (
    input  sw, end_address, read_data,
    output read_address, read_enable, PDM_out, AUD_SD, busy, done
  );

  modport slave (
    output sw, end_address, read_data,
    input  read_address, read_enable, PDM_out, AUD_SD, busy, done
  );
endinterface

// File: rtl/audio_output_pdm.sv
// Serializes OutputBuffer words LSB-first onto a 1-bit PDM stream, one bit per clk, with seamless word prefetch.
// Optional macro AUDIO_OUTPUT_LOOP_EN: wrap end_q -> 0 continuously until play is released.
module audio_output_pdm #(
  parameter int unsigned MEM_WIDTH = 16,
  parameter int unsigned MEM_DEPTH = 65536
) (
  input  logic                clk,
  input  logic                reset,
  audio_output_pdm_if.master  bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 4;
  localparam logic [BW-1:0] PREFETCH_BIT = 4'd13;
  localparam logic [BW-1:0] LAST_BIT     = 4'd15;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t               r_state, w_state;
  logic [AW-1:0]        r_end_q, w_end_q;
  logic [AW-1:0]        r_addr, w_addr;
  logic                 r_ren, w_ren;
  logic [MEM_WIDTH-1:0] r_shift, w_shift;
  logic [BW-1:0]        r_bit, w_bit;
  logic                 r_last, w_last;
  logic                 r_pdm, w_pdm;
  logic                 r_sd, w_sd;
  logic                 r_done, w_done;
  logic                 w_stop;
  logic [AW-1:0]        w_inc;
  logic [AW-1:0]        w_next_addr;

  assign w_inc = (r_addr == AW'(MEM_DEPTH - 1)) ? '0 : r_addr + AW'(1);

`ifdef AUDIO_OUTPUT_LOOP_EN
  assign w_stop      = ~bus.sw[0];
  assign w_next_addr = (r_addr == r_end_q) ? '0 : w_inc;
`else
  assign w_stop      = (r_addr == r_end_q) | ~bus.sw[0];
  assign w_next_addr = w_inc;
`endif

  // Next-state and output decode; the prefetch request is registered so it is on the bus while bit_index==14
  always_comb begin
    w_state = r_state;
    w_end_q = r_end_q;
    w_addr  = r_addr;
    w_ren   = 1'b0;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_last  = r_last;
    w_pdm   = 1'b0;
    w_sd    = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_addr = '0;
        if (bus.sw[0]) begin
          w_state = FETCH;
          w_end_q = bus.end_address;
          w_ren   = 1'b1;
        end
      end
      FETCH: w_state = LOAD;
      LOAD: begin
        w_shift = bus.read_data;
        w_bit   = '0;
        w_last  = 1'b0;
        w_state = PLAY;
      end
      PLAY: begin
        w_pdm = r_shift[r_bit] & ~bus.sw[1];
        w_sd  = ~bus.sw[1];
        w_bit = r_bit + BW'(1);
        if (r_bit == PREFETCH_BIT) begin
          w_last = w_stop;
          if (!w_stop) begin
            w_ren  = 1'b1;
            w_addr = w_next_addr;
          end
        end
        if (r_bit == LAST_BIT) begin
          if (r_last) begin
            w_done  = 1'b1;
            w_state = IDLE;
            w_addr  = '0;
          end else begin
            w_shift = bus.read_data;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_end_q <= '0;
      r_addr  <= '0;
      r_ren   <= 1'b0;
      r_shift <= '0;
      r_bit   <= '0;
      r_last  <= 1'b0;
      r_pdm   <= 1'b0;
      r_sd    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_end_q <= w_end_q;
      r_addr  <= w_addr;
      r_ren   <= w_ren;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_last  <= w_last;
      r_pdm   <= w_pdm;
      r_sd    <= w_sd;
      r_done  <= w_done;
    end
  end

  assign bus.read_address = r_addr;
  assign bus.read_enable  = r_ren;
  assign bus.PDM_out      = r_pdm;
  assign bus.AUD_SD       = r_sd;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;

endmodule
